// File: rtl/imem_loader_if.sv
// Byte-stream receive link and instruction-memory write port of imem_loader.
// slave: the loader's view; master: the image source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 16
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream -> 16-bit sequential writes.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module imem_loader #(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus,
  input  logic         i_restart,
  output logic         o_cpu_rst_n,
  output logic         o_done,
  output logic         o_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHK     = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] BASE    = BASE_ADDR[ADDR_W-1:0];
  localparam logic [16:0]       MAX_LEN = 17'd1 << ADDR_W;
`ifdef CHECKSUM_EN
  localparam state_t S_POST = S_CHK;
`else
  localparam state_t S_POST = S_DONE;
`endif

  state_t            r_state;
  logic              r_live;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [7:0]        r_hi;
  logic [15:0]       r_idx;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_cpu_rst_n;

  logic              w_accept;
  logic              w_rx_ready;
  logic              w_xfer;
  logic [15:0]       w_len;
  logic              w_last;

  // r_live keeps rx_ready low for the first cycle after reset or restart.
  assign w_accept   = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_rx_ready = r_live & w_accept & ~i_restart;
  assign w_xfer     = bus.rx_valid & w_rx_ready;
  assign w_len      = {r_len_hi, bus.rx_data};
  assign w_last     = (r_idx == (r_len - 16'd1));

  assign bus.rx_ready = w_rx_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign o_cpu_rst_n  = r_cpu_rst_n;
  assign o_done       = (r_state == S_DONE);
  assign o_err        = (r_state == S_ERR);

`ifdef CHECKSUM_EN
  logic [7:0] r_chk;

  // Running XOR of every byte after SYNC; cleared while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk <= 8'h00;
    end else if (i_restart || (r_state == S_IDLE)) begin
      r_chk <= 8'h00;
    end else if (w_xfer && (r_state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO})) begin
      r_chk <= r_chk ^ bus.rx_data;
    end else begin
      r_chk <= r_chk;
    end
  end
`endif

  // Frame parser FSM with registered write port and core reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_len_hi    <= 8'h00;
      r_len       <= 16'h0000;
      r_hi        <= 8'h00;
      r_idx       <= 16'h0000;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= BASE;
      r_wr_data   <= 16'h0000;
      r_cpu_rst_n <= 1'b0;
    end else if (i_restart) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_len_hi    <= 8'h00;
      r_len       <= 16'h0000;
      r_hi        <= 8'h00;
      r_idx       <= 16'h0000;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= BASE;
      r_wr_data   <= 16'h0000;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_wr_en     <= 1'b0;
      r_cpu_rst_n <= (r_state == S_DONE);
      if (w_xfer) begin
        case (r_state)
          S_IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              r_state <= S_LEN_HI;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_LEN_HI: begin
            r_len_hi <= bus.rx_data;
            r_state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_len <= w_len;
            r_idx <= 16'h0000;
            if (w_len == 16'h0000) begin
              r_state <= S_POST;
            end else if ({1'b0, w_len} > MAX_LEN) begin
              r_state <= S_ERR;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            r_hi    <= bus.rx_data;
            r_state <= S_DATA_LO;
          end
          S_DATA_LO: begin
            // Address arithmetic is modulo 2**ADDR_W, so wrap is natural.
            r_wr_en   <= 1'b1;
            r_wr_data <= {r_hi, bus.rx_data};
            r_wr_addr <= BASE + r_idx[ADDR_W-1:0];
            r_idx     <= r_idx + 16'd1;
            if (w_last) begin
              r_state <= S_POST;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
`ifdef CHECKSUM_EN
          S_CHK: begin
            if (bus.rx_data == r_chk) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ERR;
            end
          end
`endif
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a 16-bit-address instance at base 0 and a
// 4-bit-address instance at base 14 for overflow and wrap; honours CHECKSUM_EN.
module tb_imem_loader;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic restart0, restart4;
  logic cpu0, done0, err0, cpu4, done4, err4;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  wr_t  exp0[$];
  wr_t  exp4[$];

  imem_loader_if #(.ADDR_W(16)) bus0 ();
  imem_loader_if #(.ADDR_W(4))  bus4 ();

  imem_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .SYNC_BYTE(8'hA5)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .i_restart(restart0),
    .o_cpu_rst_n(cpu0), .o_done(done0), .o_err(err0)
  );

  imem_loader #(.ADDR_W(4), .BASE_ADDR(16'h000E), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .i_restart(restart4),
    .o_cpu_rst_n(cpu4), .o_done(done4), .o_err(err4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors: every write must match the next expected entry, in its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && bus0.wr_en === 1'b1) begin
      total++;
      if (exp0.size() == 0) begin
        bad++;
        $display("FAIL wr0_unexpected: got addr=%h data=%h cyc=%0d, required no write",
                 bus0.wr_addr, bus0.wr_data, cyc);
      end else begin
        e = exp0.pop_front();
        if (bus0.wr_addr !== e.addr || bus0.wr_data !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL wr0: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                   bus0.wr_addr, bus0.wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (rst_n === 1'b1 && bus4.wr_en === 1'b1) begin
      total++;
      if (exp4.size() == 0) begin
        bad++;
        $display("FAIL wr4_unexpected: got addr=%h data=%h cyc=%0d, required no write",
                 bus4.wr_addr, bus4.wr_data, cyc);
      end else begin
        e = exp4.pop_front();
        if ({12'h000, bus4.wr_addr} !== e.addr || bus4.wr_data !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL wr4: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                   bus4.wr_addr, bus4.wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  function automatic logic rdy(input int which);
    return (which == 0) ? bus0.rx_ready : bus4.rx_ready;
  endfunction

  task automatic drive(input int which, input logic v, input logic [7:0] b);
    if (which == 0) begin
      bus0.rx_valid = v;
      bus0.rx_data  = b;
    end else begin
      bus4.rx_valid = v;
      bus4.rx_data  = b;
    end
  endtask

  // Offer one byte from a negedge; returns at the negedge after its transfer.
  task automatic send_byte(input int which, input logic [7:0] b, input bit gap,
                           input bit push, input logic [15:0] ea, input logic [15:0] ed);
    bit  got;
    wr_t e;
    got = 1'b0;
    if (gap) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drive(which, 1'b1, b);
    #1;
    for (int i = 0; i < 64 && !got; i++) begin
      if (rdy(which) === 1'b1) begin
        if (push) begin
          e.addr = ea;
          e.data = ed;
          e.cyc  = cyc + 1;
          if (which == 0) exp0.push_back(e);
          else            exp4.push_back(e);
        end
        got = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    drive(which, 1'b0, 8'h00);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL handshake_timeout: dut=%0d byte=%h got no rx_ready, required rx_ready=1", which, b);
    end
  endtask

  // Sends SYNC, LEN and the words; the checksum of the sent bytes is returned.
  task automatic send_frame(input int which, input logic [15:0] words[$], input bit gap,
                            output logic [7:0] chk);
    logic [15:0] base, mask, len, a;
    base = (which == 0) ? 16'h0000 : 16'h000E;
    mask = (which == 0) ? 16'hFFFF : 16'h000F;
    len  = 16'(words.size());
    chk  = len[15:8] ^ len[7:0];
    send_byte(which, 8'hA5, gap, 1'b0, 16'h0, 16'h0);
    send_byte(which, len[15:8], gap, 1'b0, 16'h0, 16'h0);
    send_byte(which, len[7:0], gap, 1'b0, 16'h0, 16'h0);
    foreach (words[i]) begin
      a = (base + 16'(i)) & mask;
      send_byte(which, words[i][15:8], gap, 1'b0, 16'h0, 16'h0);
      send_byte(which, words[i][7:0], gap, 1'b1, a, words[i]);
      chk = chk ^ words[i][15:8] ^ words[i][7:0];
    end
  endtask

  task automatic pulse_restart(input int which);
    @(negedge clk);
    if (which == 0) restart0 = 1'b1; else restart4 = 1'b1;
    @(negedge clk);
    restart0 = 1'b0;
    restart4 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 6;
    if (cpu0 !== 1'b0)         begin bad++; $display("FAIL rst_cpu: got %b, required 0", cpu0); end
    if (bus0.wr_en !== 1'b0)   begin bad++; $display("FAIL rst_wr_en: got %b, required 0", bus0.wr_en); end
    if (bus0.rx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b, required 0", bus0.rx_ready); end
    if (done0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL rst_flags: got done=%b err=%b, required 0/0", done0, err0); end
    if (bus4.wr_addr !== 4'hE) begin bad++; $display("FAIL rst_addr4: got %h, required e", bus4.wr_addr); end
    if (bus0.wr_data !== 16'h0) begin bad++; $display("FAIL rst_data: got %h, required 0000", bus0.wr_data); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus0.rx_ready !== 1'b1 || bus4.rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release_ready: got %b/%b, required 1/1", bus0.rx_ready, bus4.rx_ready);
    end
  endtask

  task automatic check_done(input string name, input bit gap);
    logic [15:0] w[$];
    logic [7:0]  chk;
    w = '{16'h1234, 16'hABCD};
    send_byte(0, 8'h11, gap, 1'b0, 16'h0, 16'h0);
    send_frame(0, w, gap, chk);
`ifdef CHECKSUM_EN
    send_byte(0, chk, gap, 1'b0, 16'h0, 16'h0);
`endif
    total++;
    if (done0 !== 1'b1 || cpu0 !== 1'b0 || err0 !== 1'b0 || bus0.rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_entry: got done=%b cpu=%b err=%b rdy=%b, required 1 0 0 0",
               name, done0, cpu0, err0, bus0.rx_ready);
    end
    @(negedge clk);
    total++;
    if (cpu0 !== 1'b1 || done0 !== 1'b1) begin
      bad++;
      $display("FAIL %s_cpu_release: got cpu=%b done=%b, required 1 1", name, cpu0, done0);
    end
    total++;
    if (exp0.size() != 0) begin
      bad++;
      $display("FAIL %s_writes_missing: got %0d pending, required 0", name, exp0.size());
    end
    pulse_restart(0);
    total++;
    if (done0 !== 1'b0 || cpu0 !== 1'b0 || bus0.rx_ready !== 1'b0 || bus0.wr_addr !== 16'h0) begin
      bad++;
      $display("FAIL %s_restart: got done=%b cpu=%b rdy=%b addr=%h, required 0 0 0 0000",
               name, done0, cpu0, bus0.rx_ready, bus0.wr_addr);
    end
  endtask

  task automatic test_basic();
    check_done("basic", 1'b0);
  endtask

  task automatic test_gappy();
    check_done("gappy", 1'b1);
  endtask

  task automatic test_len_zero();
    logic [15:0] w[$];
    logic [7:0]  chk;
    w = {};
    send_frame(0, w, 1'b0, chk);
`ifdef CHECKSUM_EN
    send_byte(0, chk, 1'b0, 1'b0, 16'h0, 16'h0);
`endif
    total++;
    if (done0 !== 1'b1 || err0 !== 1'b0) begin
      bad++;
      $display("FAIL len_zero: got done=%b err=%b, required 1 0", done0, err0);
    end
    pulse_restart(0);
  endtask

  task automatic test_restart_mid();
    logic [15:0] w[$];
    logic [7:0]  chk;
    send_byte(0, 8'hA5, 1'b0, 1'b0, 16'h0, 16'h0);
    send_byte(0, 8'h00, 1'b0, 1'b0, 16'h0, 16'h0);
    send_byte(0, 8'h02, 1'b0, 1'b0, 16'h0, 16'h0);
    send_byte(0, 8'h12, 1'b0, 1'b0, 16'h0, 16'h0);
    restart0 = 1'b1;
    drive(0, 1'b1, 8'h34);
    #1;
    total++;
    if (bus0.rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL restart_gates_ready: got %b, required 0", bus0.rx_ready);
    end
    @(negedge clk);
    restart0 = 1'b0;
    drive(0, 1'b0, 8'h00);
    #1;
    total++;
    if (bus0.rx_ready !== 1'b0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL restart_mid_state: got rdy=%b done=%b, required 0 0", bus0.rx_ready, done0);
    end
    w = '{16'hBEEF};
    send_frame(0, w, 1'b0, chk);
`ifdef CHECKSUM_EN
    send_byte(0, chk, 1'b0, 1'b0, 16'h0, 16'h0);
`endif
    total++;
    if (done0 !== 1'b1 || exp0.size() != 0) begin
      bad++;
      $display("FAIL restart_fresh_frame: got done=%b pending=%0d, required 1 0", done0, exp0.size());
    end
    pulse_restart(0);
  endtask

`ifdef CHECKSUM_EN
  task automatic test_chk_fail();
    logic [15:0] w[$];
    logic [7:0]  chk;
    w = '{16'h1234, 16'hABCD};
    send_frame(0, w, 1'b0, chk);
    send_byte(0, chk ^ 8'h01, 1'b0, 1'b0, 16'h0, 16'h0);
    total++;
    if (err0 !== 1'b1 || done0 !== 1'b0 || bus0.rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL chk_fail: got err=%b done=%b rdy=%b, required 1 0 0", err0, done0, bus0.rx_ready);
    end
    @(negedge clk);
    total++;
    if (cpu0 !== 1'b0) begin
      bad++;
      $display("FAIL chk_fail_cpu: got %b, required 0", cpu0);
    end
    pulse_restart(0);
    total++;
    if (err0 !== 1'b0) begin
      bad++;
      $display("FAIL chk_fail_restart: got err=%b, required 0", err0);
    end
  endtask
`endif

  task automatic test_overflow();
    send_byte(4, 8'hA5, 1'b0, 1'b0, 16'h0, 16'h0);
    send_byte(4, 8'h00, 1'b0, 1'b0, 16'h0, 16'h0);
    send_byte(4, 8'h11, 1'b0, 1'b0, 16'h0, 16'h0);
    total++;
    if (err4 !== 1'b1 || done4 !== 1'b0 || bus4.rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL overflow: got err=%b done=%b rdy=%b, required 1 0 0", err4, done4, bus4.rx_ready);
    end
    pulse_restart(4);
  endtask

  task automatic test_wrap();
    logic [15:0] w[$];
    logic [7:0]  chk;
    w = '{16'h1111, 16'h2222, 16'h3333};
    send_frame(4, w, 1'b0, chk);
`ifdef CHECKSUM_EN
    send_byte(4, chk, 1'b0, 1'b0, 16'h0, 16'h0);
`endif
    total++;
    if (done4 !== 1'b1 || err4 !== 1'b0 || exp4.size() != 0) begin
      bad++;
      $display("FAIL wrap: got done=%b err=%b pending=%0d, required 1 0 0", done4, err4, exp4.size());
    end
  endtask

  initial begin
    restart0 = 1'b0;
    restart4 = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(4, 1'b0, 8'h00);
    test_reset();
    test_basic();
    test_gappy();
    test_len_zero();
    test_restart_mid();
`ifdef CHECKSUM_EN
    test_chk_fail();
`endif
    test_overflow();
    test_wrap();
    repeat (3) @(negedge clk);
    total++;
    if (exp0.size() != 0 || exp4.size() != 0) begin
      bad++;
      $display("FAIL final_pending: got %0d/%0d, required 0/0", exp0.size(), exp4.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
